// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pipelined video reads with absolute priority, CPU req/ack in free slots.
// Optional VRAM_ARB_STALL_COUNT_EN adds a saturating count of CPU cycles lost to video.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  n_rst_async,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  vid_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef VRAM_ARB_STALL_COUNT_EN
    ,
    output logic [15:0]           cpu_stall_cycles
`endif
);

    typedef enum logic [1:0] {StIdle, StIssued, StResp, StAck} cpu_state_e;

    cpu_state_e            state_q, state_d;
    logic                  cpu_grant;
    logic                  cpu_rd_q;
    logic [1:0]            vid_tag_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] vid_rdata_q;
    logic                  vid_rvalid_q;
    logic                  cpu_ack_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;

    always_comb begin
        state_d   = state_q;
        cpu_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req && !vid_req) begin
                    cpu_grant = 1'b1;
                    state_d   = StIssued;
                end
            end
            StIssued: state_d = StResp;
            StResp:   state_d = StAck;
            StAck:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            state_q      <= StIdle;
            cpu_rd_q     <= 1'b0;
            vid_tag_q    <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            vid_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            // Tag bit 1 marks the slot whose read data is on mem_rdata this cycle.
            vid_tag_q <= {vid_tag_q[0], vid_req};

            if (vid_req) begin
                mem_addr_q <= vid_addr;
                mem_we_q   <= 1'b0;
            end else if (cpu_grant) begin
                mem_addr_q  <= cpu_addr;
                mem_we_q    <= cpu_we;
                mem_wdata_q <= cpu_wdata;
                cpu_rd_q    <= !cpu_we;
            end else begin
                mem_we_q <= 1'b0;
            end

            vid_rvalid_q <= vid_tag_q[1];
            if (vid_tag_q[1]) begin
                vid_rdata_q <= mem_rdata;
            end

            cpu_ack_q <= (state_d == StAck);
            if (state_q == StResp && cpu_rd_q) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            stall_q <= '0;
        end else if (state_q == StIdle && cpu_req && vid_req && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign cpu_stall_cycles = stall_q;
`endif

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign vid_rdata  = vid_rdata_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expectations, a negedge monitor pops.
// Build with VRAM_ARB_STALL_COUNT_EN defined to also exercise the stall counter.
module tb_vram_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 3;

    typedef struct packed {
        logic          rd;
        logic [DW-1:0] data;
    } cpu_exp_t;

    logic          clk = 1'b0;
    logic          n_rst_async;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          vid_rvalid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STALL_COUNT_EN
    logic [15:0]   cpu_stall_cycles;
`endif

    logic [DW-1:0] vram [0:(1<<AW)-1];
    logic [DW-1:0] vid_q [$];
    cpu_exp_t      cpu_q [$];
    logic [DW-1:0] ve;
    cpu_exp_t      ce;
    int            n_checks = 0;
    int            n_fail = 0;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .n_rst_async(n_rst_async),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef VRAM_ARB_STALL_COUNT_EN
        ,
        .cpu_stall_cycles(cpu_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous VRAM model, read-before-write.
    always @(posedge clk) begin
        mem_rdata <= vram[mem_addr];
        if (mem_we) vram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (n_rst_async) begin
            if (vid_rvalid) begin
                if (vid_q.size() == 0) begin
                    check("vid_unexpected", {31'd0, vid_rvalid}, 32'd0);
                end else begin
                    ve = vid_q.pop_front();
                    check("vid_rdata", {29'd0, vid_rdata}, {29'd0, ve});
                end
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_ack_unexpected", {31'd0, cpu_ack}, 32'd0);
                end else begin
                    ce = cpu_q.pop_front();
                    if (ce.rd) check("cpu_rdata", {29'd0, cpu_rdata}, {29'd0, ce.data});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) vram[i] = i[DW-1:0];
        n_rst_async = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #2;
        check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
        tick(); tick();
        n_rst_async = 1'b1;

        // Reset mid-read: request at 0x0010 is discarded, no ack may follow.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        tick();
        check("midrd_grant_addr", {17'd0, mem_addr}, 32'h10);
        tick();
        #2 n_rst_async = 1'b0;
        #1;
        check("midrd_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("midrd_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrd_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("midrd_cpu_rdata", {29'd0, cpu_rdata}, 32'd0);
        check("midrd_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
        cpu_req = 1'b0;
        tick();
        n_rst_async = 1'b1;
        tick(); tick(); tick(); tick();

        // Write 0x1234 <= 5, then read it back; ack must not regrant the held request.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 3'b101;
        cpu_q.push_back('{rd: 1'b0, data: 3'b000});
        tick();
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_addr", {17'd0, mem_addr}, 32'h1234);
        check("wr_mem_wdata", {29'd0, mem_wdata}, 32'd5);
        tick();
        check("wr_mem_we_one_cycle", {31'd0, mem_we}, 32'd0);
        check("wr_ack_early", {31'd0, cpu_ack}, 32'd0);
        tick();
        check("wr_ack", {31'd0, cpu_ack}, 32'd1);
        tick();
        check("wr_no_regrant", {31'd0, mem_we}, 32'd0);
        check("wr_ack_one_cycle", {31'd0, cpu_ack}, 32'd0);
        cpu_we = 1'b0;
        cpu_q.push_back('{rd: 1'b1, data: 3'b101});
        tick();
        check("rd_grant_addr", {17'd0, mem_addr}, 32'h1234);
        tick();
        check("rd_ack_early", {31'd0, cpu_ack}, 32'd0);
        tick();
        check("rd_ack", {31'd0, cpu_ack}, 32'd1);
        check("rd_data", {29'd0, cpu_rdata}, 32'd5);
        tick();
        cpu_req = 1'b0;
        tick();

        // Streaming video 0..7.
        for (int i = 0; i < 8; i++) begin
            vid_req = 1'b1; vid_addr = AW'(i);
            vid_q.push_back(DW'(i));
            tick();
            check("stream_rvalid", {31'd0, vid_rvalid}, (i >= 2) ? 32'd1 : 32'd0);
        end
        vid_req = 1'b0;
        tick();
        check("stream_rvalid_tail0", {31'd0, vid_rvalid}, 32'd1);
        tick();
        check("stream_rvalid_tail1", {31'd0, vid_rvalid}, 32'd1);
        tick();
        check("stream_rvalid_end", {31'd0, vid_rvalid}, 32'd0);

        // Contention: CPU read of 0x0023 held for 20 video cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0023;
        for (int i = 0; i < 20; i++) begin
            vid_req = 1'b1; vid_addr = AW'(15'h0100 + i);
            vid_q.push_back(DW'(i));
            tick();
            check("cont_vid_addr", {17'd0, mem_addr}, 32'h100 + i);
            check("cont_no_cpu", {31'd0, mem_we}, 32'd0);
        end
        vid_req = 1'b0;
        cpu_q.push_back('{rd: 1'b1, data: 3'd3});
        tick();
        check("cont_grant_addr", {17'd0, mem_addr}, 32'h23);
`ifdef VRAM_ARB_STALL_COUNT_EN
        check("cont_stall_cycles", {16'd0, cpu_stall_cycles}, 32'd20);
`endif
        tick(); tick();
        check("cont_ack", {31'd0, cpu_ack}, 32'd1);
        tick();
        cpu_req = 1'b0;
        tick();

        // CPU read of 0x0045 in flight while video streams.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0045;
        cpu_q.push_back('{rd: 1'b1, data: 3'd5});
        tick();
        for (int i = 0; i < 6; i++) begin
            vid_req = 1'b1; vid_addr = AW'(15'h0200 + i);
            vid_q.push_back(DW'(i));
            tick();
            check("fly_vid_addr", {17'd0, mem_addr}, 32'h200 + i);
            check("fly_ack", {31'd0, cpu_ack}, (i == 1) ? 32'd1 : 32'd0);
            if (i == 1) check("fly_rdata", {29'd0, cpu_rdata}, 32'd5);
            if (i == 2) cpu_req = 1'b0;
        end
        vid_req = 1'b0;
        tick(); tick(); tick(); tick();

`ifdef VRAM_ARB_STALL_COUNT_EN
        // Saturation: 70000 contended cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0007;
        for (int i = 0; i < 70000; i++) begin
            vid_req = 1'b1; vid_addr = AW'(i[2:0]);
            vid_q.push_back(DW'(i[2:0]));
            tick();
        end
        check("sat_stall", {16'd0, cpu_stall_cycles}, 32'hFFFF);
        cpu_req = 1'b0;
        vid_q.push_back(3'd0); vid_addr = '0;
        tick();
        check("sat_hold", {16'd0, cpu_stall_cycles}, 32'hFFFF);
        vid_req = 1'b0;
        tick(); tick(); tick(); tick();
`endif

        check("vid_queue_drained", vid_q.size(), 32'd0);
        check("cpu_queue_drained", cpu_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
